alu_nbit_7seg_seq: RTL and testbench
====================================

Name: alu_nbit_7seg_seq

Overview:
Parametrised successor to the 4-bit adder/7-seg top. It has a WIDTH-bit ALU with four modes, including accumulate. The result register is captured on a synchronised load strobe. A sequential double-dabble converter drives a DIGITS-digit multiplexed 7-segment display, with sign display and leading-zero blanking. It sits at board top level: switches in, LEDs and 7-seg out.

Parameters:
WIDTH, 4, operand width in bits (2..16)
DIGITS, 4, 7-seg digits driven; must be >= BCD digits of (2^(WIDTH+1)-1) plus 1 for sign
REFRESH_DIV, 100000, clk cycles each digit stays active (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
a  input  WIDTH  operand A (switches)
b  input  WIDTH  operand B (switches)
op  input  2  mode: 00 ADD, 01 SUB, 10 INC, 11 ACC
cin  input  1  carry in, used by ADD only
load  input  1  asynchronous button; rising edge captures a new result
result_led  output  WIDTH+1  registered result magnitude
ovf_led  output  1  registered carry-out (bit WIDTH of sum)
neg_led  output  1  registered sign (SUB with a<b)
busy  output  1  BCD conversion in progress
seg  output  7  cathodes, active-low, seg[0]=a .. seg[6]=g
an  output  DIGITS  anodes, active-low one-hot

Behaviour:
- Reset (async, rst_n=0): result, acc, ovf, neg, BCD display buffer, sync flops, refresh counter and digit index = 0. busy=0. an = ~1 (digit 0 on). seg = 7'b1000000 ("0").
- Load path: 2-flop synchroniser, then rising-edge detect. load high first sampled at edge N → result registers update at edge N+3. Level-held load produces exactly one capture.
- ALU (combinational, sampled at capture):
  - ADD: {ovf,r} = a + b + cin.
  - SUB: if a>=b then r=a-b, neg=0; else r=b-a, neg=1. ovf=0. cin ignored.
  - INC: {ovf,r} = a + 1.
  - ACC: {ovf,r} = acc + a, where acc = low WIDTH bits of the current result. Wraps mod 2^WIDTH with ovf=1 on carry.
  - result_led = {ovf,r} for ADD/INC/ACC, {1'b0,r} for SUB.
- Converter FSM states:
  - IDLE → LOAD on the cycle after capture.
  - LOAD → SHIFT (WIDTH+1 cycles, add-3 then shift each cycle).
  - SHIFT → DONE.
  - DONE copies BCD + neg into the display buffer → IDLE.
  - busy=1 in LOAD/SHIFT/DONE; capture to display update latency = WIDTH+3 cycles.
- Load edge while busy=1: dropped. Result registers stay unchanged and no queueing occurs.
- Display: old buffer stays shown until DONE, so there is no partial value.
- Scan: refresh counter counts 0..REFRESH_DIV-1. At wrap, digit index increments and wraps DIGITS-1→0.
- Digit content:
  - digit 0 is always shown.
  - digits above the most significant non-zero BCD digit are blank (seg=7'h7F).
  - digit DIGITS-1 shows "-" (7'b0111111) when neg=1, otherwise follows the blanking rule.
- Anode/segment change on the same edge. No ghosting blanking cycle is required.
- rst_n asserted mid-conversion: FSM returns to IDLE and the display shows "0".

Decomposition:
- Package alu7_pkg holds:
  - op codes OP_ADD/OP_SUB/OP_INC/OP_ACC
  - the seg patterns for 0-9, blank and minus as constants
  - a function returning the BCD digit count for a width
- Sub-module bin2bcd_seq: sequential double-dabble with start/busy/done and a parametrised input width. The top instantiates it.
- The scanner stays inline.

Test Plan:
- Reset: rst_n=0 then release → an=4'b1110, seg=7'b1000000, result_led=0, busy=0.
- ADD, WIDTH=4, REFRESH_DIV=4: a=15, b=15, cin=1, pulse load → result_led=31, ovf=1, busy for 7 cycles. Scan shows digit0 "1", digit1 "3", digits 2-3 blank.
- SUB: a=3, b=9 → result_led=6, neg=1. Digit0 "6", digit3 "-", digits 1-2 blank. Then a=9, b=3 → neg=0, "6" only.
- ACC wrap: result=0, a=6, load ×3 → 6, 12, then 18&15=2 with ovf=1. Each captures exactly once while load is held for 10 cycles.
- Load while busy: second load edge 2 cycles after first → ignored, result from first load only. Async rst_n mid-SHIFT → busy=0, display "0".

Source files
------------

// File: rtl/alu7_pkg.sv
// Shared op codes, 7-segment patterns and converter state type for the
// N-bit ALU / 7-segment display top.
package alu7_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_ACC = 2'b11;

  // Active-low cathodes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;

  typedef enum logic [1:0] {
    CONV_IDLE,
    CONV_LOAD,
    CONV_SHIFT,
    CONV_DONE
  } conv_state_t;

  // Decimal digits needed to show the largest unsigned value of `width` bits
  function automatic int unsigned bcd_digits(input int unsigned width);
    int unsigned v;
    int unsigned n;
    v = (32'd1 << width) - 32'd1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (v != 0) begin
        n++;
        v = v / 32'd10;
      end
    end
    if (n == 0) n = 1;
    return n;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/alu_nbit_7seg_bin2bcd_seq.sv
// Sequential double-dabble: one add-3/shift step per cycle, IN_W steps per
// conversion, result held in bcd until the next start.
module bin2bcd_seq
  import alu7_pkg::*;
#(
  parameter int unsigned IN_W = 5,
  parameter int unsigned ND   = bcd_digits(IN_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [IN_W-1:0] bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  localparam int unsigned BW = 4 * ND;
  localparam int unsigned SW = BW + IN_W;
  localparam int unsigned CW = $clog2(IN_W + 1);

  conv_state_t   state_q, state_d;
  logic [SW-1:0] sr_q, sr_d, adj;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    adj     = sr_q;
    case (state_q)
      CONV_IDLE: if (start) state_d = CONV_LOAD;
      CONV_LOAD: begin
        sr_d    = {BW'(0), bin};
        cnt_d   = '0;
        state_d = CONV_SHIFT;
      end
      CONV_SHIFT: begin
        for (int d = 0; d < int'(ND); d++) begin
          if (adj[int'(IN_W) + 4*d +: 4] >= 4'd5)
            adj[int'(IN_W) + 4*d +: 4] = adj[int'(IN_W) + 4*d +: 4] + 4'd3;
        end
        sr_d  = adj << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(IN_W - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != CONV_IDLE);
      done    <= (state_d == CONV_DONE);
    end
  end

  assign bcd = sr_q[SW-1:IN_W];

endmodule

// File: rtl/alu_nbit_7seg_seq.sv
// Board top: WIDTH-bit ALU captured on a synchronised load button, converted
// to BCD and shown on a multiplexed signed 7-segment display.
module alu_nbit_7seg_seq
  import alu7_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [1:0]        op,
  input  logic              cin,
  input  logic              load,
  output logic [WIDTH:0]    result_led,
  output logic              ovf_led,
  output logic              neg_led,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int unsigned RES_W = WIDTH + 1;
  localparam int unsigned ND    = bcd_digits(RES_W);
  localparam int unsigned CW    = $clog2(REFRESH_DIV);
  localparam int unsigned IW    = $clog2(DIGITS);

  logic [1:0]      sync_q;
  logic            prev_q, rise_q, capture;
  logic [RES_W-1:0] alu_sum;
  logic            alu_neg;
  logic            conv_done;
  logic [4*ND-1:0] conv_bcd, disp_bcd_q;
  logic            disp_neg_q;
  logic [CW-1:0]   refresh_q;
  logic [IW-1:0]   dig_q, dig_d;
  logic            wrap;
  logic [ND-1:0]   shown;
  logic            above;
  logic [6:0]      pat;

  // Button synchroniser plus registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], load};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
    end
  end

  // Edges arriving mid-conversion are dropped, never queued
  assign capture = rise_q & ~busy;

  always_comb begin
    alu_sum = '0;
    alu_neg = 1'b0;
    case (op)
      OP_ADD: alu_sum = {1'b0, a} + {1'b0, b} + RES_W'(cin);
      OP_SUB: begin
        if (a >= b) begin
          alu_sum = {1'b0, a - b};
        end else begin
          alu_sum = {1'b0, b - a};
          alu_neg = 1'b1;
        end
      end
      OP_INC: alu_sum = {1'b0, a} + RES_W'(1);
      OP_ACC: alu_sum = {1'b0, result_led[WIDTH-1:0]} + {1'b0, a};
      default: alu_sum = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_led <= '0;
      ovf_led    <= 1'b0;
      neg_led    <= 1'b0;
    end else if (capture) begin
      result_led <= alu_sum;
      ovf_led    <= alu_sum[WIDTH];
      neg_led    <= alu_neg;
    end
  end

  bin2bcd_seq #(
    .IN_W (RES_W),
    .ND   (ND)
  ) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (capture),
    .bin   (result_led),
    .busy  (busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display buffer only changes once a conversion has fully finished
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd;
      disp_neg_q <= neg_led;
    end
  end

  assign wrap = (refresh_q == CW'(REFRESH_DIV - 1));

  always_comb begin
    dig_d = dig_q;
    if (wrap) dig_d = (dig_q == IW'(DIGITS - 1)) ? '0 : dig_q + IW'(1);
  end

  // Leading-zero blanking, with the top digit reserved for the sign
  always_comb begin
    above = 1'b0;
    shown = '0;
    for (int k = int'(ND) - 1; k >= 0; k--) begin
      above    = above | (|disp_bcd_q[4*k +: 4]);
      shown[k] = above | (k == 0);
    end
    pat = SEG_BLANK;
    for (int k = 0; k < int'(ND); k++) begin
      if (dig_d == IW'(k) && shown[k]) pat = seg_of(disp_bcd_q[4*k +: 4]);
    end
    if (disp_neg_q && dig_d == IW'(DIGITS - 1)) pat = SEG_MINUS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_q <= '0;
      dig_q     <= '0;
      an        <= ~DIGITS'(1);
      seg       <= SEG_0;
    end else begin
      refresh_q <= wrap ? '0 : refresh_q + CW'(1);
      dig_q     <= dig_d;
      an        <= ~(DIGITS'(1) << dig_d);
      seg       <= pat;
    end
  end

endmodule

// File: tb/tb_alu_nbit_7seg_seq.sv
// Directed bench for alu_nbit_7seg_seq at WIDTH=4, DIGITS=4, REFRESH_DIV=4:
// capture latency, ALU modes, busy drop, display scan and mid-conversion reset.
module tb_alu_nbit_7seg_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a, b;
  logic [1:0] op;
  logic       cin, load;
  logic [4:0] result_led;
  logic       ovf_led, neg_led, busy;
  logic [6:0] seg;
  logic [3:0] an;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  alu_nbit_7seg_seq #(
    .WIDTH       (4),
    .DIGITS      (4),
    .REFRESH_DIV (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .op         (op),
    .cin        (cin),
    .load       (load),
    .result_led (result_led),
    .ovf_led    (ovf_led),
    .neg_led    (neg_led),
    .busy       (busy),
    .seg        (seg),
    .an         (an)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic get_digit(input int d, output logic [6:0] s, output bit found);
    logic [3:0] target;
    target = ~(4'b0001 << d);
    s      = 7'h00;
    found  = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (an === target) begin
        s     = seg;
        found = 1'b1;
      end
    end
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [6:0] exp);
    logic [6:0] s;
    bit         f;
    get_digit(d, s, f);
    chk({tag, "_found"}, 32'(f), 32'd1);
    chk(tag, 32'(s), 32'(exp));
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    load = 1'b1;
    repeat (hold) @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    a = 4'd0; b = 4'd0; op = 2'b00; cin = 1'b0; load = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_result", 32'(result_led), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_an", 32'(an), 32'hE);
    chk("post_rst_seg", 32'(seg), 32'h40);

    // ADD 15+15+1: capture exactly three edges after first sampled high
    a = 4'd15; b = 4'd15; cin = 1'b1; op = 2'b00;
    load = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("add_pre_capture", 32'(result_led), 32'd0);
    @(negedge clk);
    chk("add_result", 32'(result_led), 32'd31);
    chk("add_ovf", 32'(ovf_led), 32'd1);
    chk("add_neg", 32'(neg_led), 32'd0);
    chk("add_busy", 32'(busy), 32'd1);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("add_busy_cycles", 32'(n), 32'd7);
    load = 1'b0;
    chk("add_result_held", 32'(result_led), 32'd31);
    repeat (3) @(negedge clk);
    chk_digit("add_d0", 0, 7'h79);
    chk_digit("add_d1", 1, 7'h30);
    chk_digit("add_d2", 2, 7'h7F);
    chk_digit("add_d3", 3, 7'h7F);

    // SUB with a<b shows a minus sign
    op = 2'b01; a = 4'd3; b = 4'd9; cin = 1'b1;
    press(4);
    repeat (12) @(negedge clk);
    chk("sub_neg_result", 32'(result_led), 32'd6);
    chk("sub_neg_flag", 32'(neg_led), 32'd1);
    chk("sub_neg_ovf", 32'(ovf_led), 32'd0);
    chk_digit("sub_neg_d0", 0, 7'h02);
    chk_digit("sub_neg_d1", 1, 7'h7F);
    chk_digit("sub_neg_d2", 2, 7'h7F);
    chk_digit("sub_neg_d3", 3, 7'h3F);

    a = 4'd9; b = 4'd3;
    press(4);
    repeat (12) @(negedge clk);
    chk("sub_pos_result", 32'(result_led), 32'd6);
    chk("sub_pos_flag", 32'(neg_led), 32'd0);
    chk_digit("sub_pos_d0", 0, 7'h02);
    chk_digit("sub_pos_d3", 3, 7'h7F);

    // INC with carry out
    op = 2'b10; a = 4'd15; cin = 1'b0;
    press(4);
    repeat (12) @(negedge clk);
    chk("inc_result", 32'(result_led), 32'd16);
    chk("inc_ovf", 32'(ovf_led), 32'd1);
    chk_digit("inc_d0", 0, 7'h02);
    chk_digit("inc_d1", 1, 7'h79);

    // Clear to zero, then accumulate 6 three times with long-held load
    op = 2'b01; a = 4'd0; b = 4'd0;
    press(4);
    repeat (12) @(negedge clk);
    chk("clr_result", 32'(result_led), 32'd0);

    op = 2'b11; a = 4'd6;
    press(10);
    repeat (12) @(negedge clk);
    chk("acc1_result", 32'(result_led), 32'd6);
    chk("acc1_ovf", 32'(ovf_led), 32'd0);
    press(10);
    repeat (12) @(negedge clk);
    chk("acc2_result", 32'(result_led), 32'd12);
    press(10);
    repeat (12) @(negedge clk);
    chk("acc3_result", 32'(result_led), 32'd18);
    chk("acc3_ovf", 32'(ovf_led), 32'd1);
    chk_digit("acc3_d0", 0, 7'h00);
    chk_digit("acc3_d1", 1, 7'h79);

    // Second edge two cycles after the first lands while busy
    a = 4'd1;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (15) @(negedge clk);
    chk("drop_result", 32'(result_led), 32'd3);
    chk("drop_ovf", 32'(ovf_led), 32'd0);
    chk_digit("drop_d0", 0, 7'h30);
    chk_digit("drop_d1", 1, 7'h7F);

    // Reset while the converter is shifting
    op = 2'b00; a = 4'd7; b = 4'd1; cin = 1'b0;
    press(2);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_busy_seen", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_result", 32'(result_led), 32'd0);
    chk("mid_rst_seg", 32'(seg), 32'h40);
    chk("mid_rst_an", 32'(an), 32'hE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid_after_busy", 32'(busy), 32'd0);
    chk("mid_after_result", 32'(result_led), 32'd0);
    chk_digit("mid_after_d0", 0, 7'h40);
    chk_digit("mid_after_d1", 1, 7'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
